// File: rtl/ram_cycle_seq.sv
// DRAM cycle sequencer: runs one RAS/CAS access per clock-generator slot for
// the shifter or the CPU, and fills otherwise idle slots with RAS-only refresh.
module ram_cycle_seq #(
    parameter int RAM_AW  = 20,
    parameter int REF_DIV = 480
) (
    input  logic                  clk32,
    input  logic                  reset,
    input  logic                  cyc_en,
    input  logic                  cycsel,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [RAM_AW-1:0]     cpu_addr,
    output logic                  cpu_ack,
    input  logic                  vid_req,
    input  logic [RAM_AW-1:0]     vid_addr,
    output logic                  vid_ack,
    output logic [RAM_AW/2-1:0]   ram_addr,
    output logic                  ras_n,
    output logic                  cas_n,
    output logic                  we_n,
    output logic                  sync_err
);

    localparam int HW = RAM_AW / 2;
    localparam int TW = (REF_DIV > 1) ? $clog2(REF_DIV) : 1;

    // Requester handshake: req is a level held by the requester; a grant is
    // taken only at a slot start, and ack is a single-cycle pulse at phase 5.
    // A slot aborted by an early cyc_en never acks, so the requester simply
    // keeps req high and is served in a later slot.
    typedef enum logic [1:0] {ST_IDLE, ST_ROW, ST_COL, ST_PRE} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_CPU, OWN_VID, OWN_REF} owner_t;

    state_t            state_q, state_d;
    owner_t            owner_q, owner_d;
    owner_t            grant_owner;
    logic [2:0]        p_q, p_d;
    logic [RAM_AW-1:0] addr_q, addr_d;
    logic              wr_q, wr_d;
    logic [HW-1:0]     ref_row_q, ref_row_d;
    logic              ref_due_q, ref_due_d;
    logic [TW-1:0]     ref_cnt_q, ref_cnt_d;
    logic              armed_q, armed_d;
    logic              sat_q, sat_d;
    logic [HW-1:0]     ram_addr_q, ram_addr_d;
    logic              ras_n_q, ras_n_d;
    logic              cas_n_q, cas_n_d;
    logic              we_n_q, we_n_d;
    logic              cpu_ack_q, cpu_ack_d;
    logic              vid_ack_q, vid_ack_d;
    logic              sync_err_q, sync_err_d;

    logic early, grant, ref_wrap, ref_done, sat_hit, in_ras;

    // Slot phase, ownership and FSM next state.
    always_comb begin
        early = cyc_en && (p_q != 3'd7) && (state_q != ST_IDLE);
        if (cycsel) begin
            grant_owner = vid_req ? OWN_VID : (ref_due_q ? OWN_REF : OWN_NONE);
        end else begin
            grant_owner = cpu_req ? OWN_CPU : (ref_due_q ? OWN_REF : OWN_NONE);
        end
        grant = cyc_en && !early && (grant_owner != OWN_NONE);

        p_d     = cyc_en ? 3'd0 : ((p_q == 3'd7) ? 3'd7 : p_q + 3'd1);
        state_d = state_q;
        owner_d = owner_q;
        addr_d  = addr_q;
        wr_d    = wr_q;

        if (cyc_en) begin
            if (grant) begin
                state_d = ST_ROW;
                owner_d = grant_owner;
                addr_d  = cycsel ? vid_addr : cpu_addr;
                wr_d    = (grant_owner == OWN_CPU) && cpu_we;
            end else begin
                state_d = ST_IDLE;
                owner_d = OWN_NONE;
                wr_d    = 1'b0;
            end
        end else begin
            case (state_q)
                ST_ROW: begin
                    // Refresh never opens a column: it holds ROW until precharge.
                    if (owner_q == OWN_REF) begin
                        if (p_d == 3'd6) state_d = ST_PRE;
                    end else if (p_d == 3'd2) begin
                        state_d = ST_COL;
                    end
                end
                ST_COL: begin
                    if (p_d == 3'd6) state_d = ST_PRE;
                end
                ST_PRE: begin
                    if (p_d == 3'd7) begin
                        state_d = ST_IDLE;
                        owner_d = OWN_NONE;
                        wr_d    = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Refresh timer and row counter; a wrap in the clearing clock keeps ref_due.
    always_comb begin
        ref_wrap  = (ref_cnt_q == TW'(REF_DIV - 1));
        ref_cnt_d = ref_wrap ? '0 : ref_cnt_q + TW'(1);
        ref_done  = (state_d == ST_ROW) && (owner_d == OWN_REF) && (p_d == 3'd5);
        ref_row_d = ref_done ? ref_row_q + HW'(1) : ref_row_q;
        ref_due_d = ref_wrap ? 1'b1 : (ref_done ? 1'b0 : ref_due_q);
    end

    // Slot-timing supervision. Missing-strobe detection is armed by the first
    // cyc_en after reset, so the wait for the generator to start is not an error.
    always_comb begin
        sat_hit    = !cyc_en && (p_q == 3'd7) && armed_q;
        sync_err_d = early || (sat_hit && !sat_q);
        sat_d      = cyc_en ? 1'b0 : (sat_q || sat_hit);
        armed_d    = armed_q || cyc_en;
    end

    // Pin outputs are decoded from the next phase/state so the registered pins
    // line up with the phase register.
    always_comb begin
        ras_n_d    = 1'b1;
        cas_n_d    = 1'b1;
        we_n_d     = 1'b1;
        cpu_ack_d  = 1'b0;
        vid_ack_d  = 1'b0;
        ram_addr_d = ram_addr_q;
        in_ras     = (p_d >= 3'd1) && (p_d <= 3'd5);

        if (state_d != ST_IDLE) begin
            if (owner_d == OWN_REF) begin
                if (grant) ram_addr_d = ref_row_q;
                ras_n_d = !in_ras;
            end else begin
                ram_addr_d = (p_d <= 3'd1) ? addr_d[RAM_AW-1:HW] : addr_d[HW-1:0];
                ras_n_d    = !in_ras;
                cas_n_d    = !((p_d >= 3'd3) && (p_d <= 3'd5));
                we_n_d     = !(wr_d && (p_d >= 3'd2) && (p_d <= 3'd5));
                cpu_ack_d  = (owner_d == OWN_CPU) && (p_d == 3'd5);
                vid_ack_d  = (owner_d == OWN_VID) && (p_d == 3'd5);
            end
        end
    end

    always_ff @(posedge clk32) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            owner_q    <= OWN_NONE;
            p_q        <= 3'd7;
            addr_q     <= '0;
            wr_q       <= 1'b0;
            ref_row_q  <= '0;
            ref_due_q  <= 1'b0;
            ref_cnt_q  <= '0;
            armed_q    <= 1'b0;
            sat_q      <= 1'b0;
            ram_addr_q <= '0;
            ras_n_q    <= 1'b1;
            cas_n_q    <= 1'b1;
            we_n_q     <= 1'b1;
            cpu_ack_q  <= 1'b0;
            vid_ack_q  <= 1'b0;
            sync_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            p_q        <= p_d;
            addr_q     <= addr_d;
            wr_q       <= wr_d;
            ref_row_q  <= ref_row_d;
            ref_due_q  <= ref_due_d;
            ref_cnt_q  <= ref_cnt_d;
            armed_q    <= armed_d;
            sat_q      <= sat_d;
            ram_addr_q <= ram_addr_d;
            ras_n_q    <= ras_n_d;
            cas_n_q    <= cas_n_d;
            we_n_q     <= we_n_d;
            cpu_ack_q  <= cpu_ack_d;
            vid_ack_q  <= vid_ack_d;
            sync_err_q <= sync_err_d;
        end
    end

    assign ram_addr = ram_addr_q;
    assign ras_n    = ras_n_q;
    assign cas_n    = cas_n_q;
    assign we_n     = we_n_q;
    assign cpu_ack  = cpu_ack_q;
    assign vid_ack  = vid_ack_q;
    assign sync_err = sync_err_q;

endmodule

// File: tb/tb_ram_cycle_seq.sv
// Self-checking bench for ram_cycle_seq: per-phase strobe checks per slot and an
// ack scoreboard fed at every grant.
`timescale 1ns/1ps
module tb_ram_cycle_seq;

    localparam int AW = 20;
    localparam int HW = AW / 2;
    localparam int K_IDLE = 0;
    localparam int K_CPU  = 1;
    localparam int K_VID  = 2;
    localparam int K_REFQ = 3;  // refresh or idle, decided by the DUT's ref timer

    logic          clk32;
    logic          reset;
    logic          cyc_en;
    logic          cycsel;
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic          cpu_ack;
    logic          vid_req;
    logic [AW-1:0] vid_addr;
    logic          vid_ack;
    logic [HW-1:0] ram_addr;
    logic          ras_n;
    logic          cas_n;
    logic          we_n;
    logic          sync_err;

    int n_checks = 0;
    int n_errors = 0;
    int n_ref    = 0;
    logic [HW-1:0] exp_ref_row = '0;
    logic [1:0]    exp_q[$];
    logic [1:0]    mon_exp;

    ram_cycle_seq #(.RAM_AW(AW), .REF_DIV(20)) dut (
        .clk32(clk32), .reset(reset), .cyc_en(cyc_en), .cycsel(cycsel),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_ack(cpu_ack),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack),
        .ram_addr(ram_addr), .ras_n(ras_n), .cas_n(cas_n), .we_n(we_n),
        .sync_err(sync_err)
    );

    // clock / reset
    initial clk32 = 1'b0;
    always #5 clk32 = ~clk32;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no completion, required finish before 1ms");
        $fatal(1, "timeout");
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk32);
        #1;
    endtask

    task automatic reset_checks();
        check_eq("rst_ras_n", 32'(ras_n), 32'd1);
        check_eq("rst_cas_n", 32'(cas_n), 32'd1);
        check_eq("rst_we_n", 32'(we_n), 32'd1);
        check_eq("rst_ram_addr", 32'(ram_addr), 32'd0);
        check_eq("rst_acks", 32'({vid_ack, cpu_ack}), 32'd0);
        check_eq("rst_sync_err", 32'(sync_err), 32'd0);
    endtask

    // Eight phases of an idle slot; optionally expects the abort sync_err at p0.
    task automatic idle_checks(input bit sync_first);
        for (int ph = 0; ph < 8; ph++) begin
            check_eq("idle_ras_n", 32'(ras_n), 32'd1);
            check_eq("idle_cas_n", 32'(cas_n), 32'd1);
            check_eq("idle_we_n", 32'(we_n), 32'd1);
            check_eq("idle_acks", 32'({vid_ack, cpu_ack}), 32'd0);
            check_eq("idle_sync_err", 32'(sync_err), 32'(sync_first && ph == 0));
            if (ph < 7) step();
        end
    endtask

    // Drives one slot from the p7 cycle and checks phases 0..7.
    // cut_kind 1: early cyc_en after phase cut_at; 2: reset after phase cut_at.
    task automatic run_slot(input logic sel, input int kind, input logic [AW-1:0] addr,
                            input logic we, input int cut_at, input int cut_kind);
        logic [HW-1:0] row, col;
        logic exp_ras, exp_cas, exp_we, exp_ca, exp_va;
        bit is_ref;
        row    = addr[AW-1:HW];
        col    = addr[HW-1:0];
        is_ref = 1'b0;
        cycsel   = sel;
        cpu_addr = addr;
        vid_addr = addr;
        cpu_we   = we;
        cyc_en   = 1'b1;
        if (cut_kind == 0 && kind == K_CPU) exp_q.push_back(2'b01);
        if (cut_kind == 0 && kind == K_VID) exp_q.push_back(2'b10);
        step();
        cyc_en   = 1'b0;
        cpu_addr = AW'($urandom);
        vid_addr = AW'($urandom);
        cpu_we   = ~we;
        for (int ph = 0; ph < 8; ph++) begin
            if (kind == K_REFQ && ph == 1) is_ref = (ras_n == 1'b0);
            exp_ras = 1'b1; exp_cas = 1'b1; exp_we = 1'b1; exp_ca = 1'b0; exp_va = 1'b0;
            if (kind == K_CPU || kind == K_VID) begin
                exp_ras = !(ph >= 1 && ph <= 5);
                exp_cas = !(ph >= 3 && ph <= 5);
                exp_we  = !(kind == K_CPU && we && ph >= 2 && ph <= 5);
                exp_ca  = (kind == K_CPU && ph == 5);
                exp_va  = (kind == K_VID && ph == 5);
                check_eq("ram_addr", 32'(ram_addr), 32'((ph <= 1) ? row : col));
            end else if (kind == K_REFQ && is_ref) begin
                exp_ras = !(ph >= 1 && ph <= 5);
                check_eq("ref_row_addr", 32'(ram_addr), 32'(exp_ref_row));
            end
            check_eq("ras_n", 32'(ras_n), 32'(exp_ras));
            check_eq("cas_n", 32'(cas_n), 32'(exp_cas));
            check_eq("we_n", 32'(we_n), 32'(exp_we));
            check_eq("cpu_ack", 32'(cpu_ack), 32'(exp_ca));
            check_eq("vid_ack", 32'(vid_ack), 32'(exp_va));
            check_eq("sync_err", 32'(sync_err), 32'd0);
            if (ph == cut_at) begin
                if (cut_kind == 1) begin
                    cyc_en = 1'b1;
                    cycsel = 1'b0;
                    step();
                    cyc_en = 1'b0;
                    idle_checks(1'b1);
                end else begin
                    reset = 1'b1;
                    step();
                    reset_checks();
                    step();
                    reset_checks();
                    reset = 1'b0;
                end
                return;
            end
            if (ph < 7) step();
        end
        if (is_ref) begin
            exp_ref_row = exp_ref_row + HW'(1);
            n_ref++;
        end
    endtask

    // scoreboard: every ack pulse must match the oldest outstanding grant
    always @(negedge clk32) begin
        if (cpu_ack || vid_ack) begin
            if (exp_q.size() == 0) begin
                check_eq("ack_unexpected", 32'({vid_ack, cpu_ack}), 32'd0);
            end else begin
                mon_exp = exp_q.pop_front();
                check_eq("ack_order", 32'({vid_ack, cpu_ack}), 32'(mon_exp));
            end
        end
    end

    initial begin
        reset = 1'b1; cyc_en = 1'b0; cycsel = 1'b0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0;
        vid_req = 1'b0; vid_addr = '0;
        repeat (3) step();
        reset_checks();
        reset = 1'b0;
        step();
        step();
        check_eq("post_rst_sync_err", 32'(sync_err), 32'd0);

        // CPU read then write, then random CPU accesses
        cpu_req = 1'b1;
        run_slot(1'b0, K_CPU, 20'h5A3C7, 1'b0, -1, 0);
        run_slot(1'b0, K_CPU, 20'h5A3C7, 1'b1, -1, 0);
        for (int i = 0; i < 6; i++) run_slot(1'b0, K_CPU, AW'($urandom), 1'($urandom), -1, 0);

        // alternating ownership, both requesting
        vid_req = 1'b1;
        for (int i = 0; i < 8; i++)
            run_slot(1'(i % 2), (i % 2) ? K_VID : K_CPU, AW'($urandom), 1'($urandom), -1, 0);

        // refresh only: long enough for ref_row to wrap past 0x3FF
        cpu_req = 1'b0;
        vid_req = 1'b0;
        for (int i = 0; i < 2600; i++)
            run_slot(1'($urandom_range(0, 1)), K_REFQ, AW'($urandom), 1'b0, -1, 0);
        check_eq("ref_count_in_range", 32'(n_ref >= 1038 && n_ref <= 1042), 32'd1);

        // CPU keeps its slots; refresh must land in video slots only
        cpu_req = 1'b1;
        for (int i = 0; i < 40; i++)
            run_slot(1'(i % 2), (i % 2) ? K_REFQ : K_CPU, AW'($urandom), 1'($urandom), -1, 0);

        // early cyc_en at p3 of a CPU write, then a normal CPU slot
        run_slot(1'b0, K_CPU, AW'($urandom), 1'b1, 3, 1);
        run_slot(1'b0, K_CPU, AW'($urandom), 1'b0, -1, 0);

        // missing strobe for 20 clocks
        for (int i = 1; i <= 20; i++) begin
            step();
            check_eq("miss_sync_err", 32'(sync_err), 32'(i == 1));
            check_eq("miss_ras_n", 32'(ras_n), 32'd1);
            check_eq("miss_cas_n", 32'(cas_n), 32'd1);
        end
        run_slot(1'b0, K_CPU, AW'($urandom), 1'b1, -1, 0);

        // reset at p4 of a video slot, then resume
        vid_req = 1'b1;
        run_slot(1'b1, K_VID, AW'($urandom), 1'b0, 4, 2);
        run_slot(1'b1, K_VID, AW'($urandom), 1'b0, -1, 0);

        repeat (4) step();
        check_eq("ack_queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
